fetch_queue: RTL

Parametrised instruction-fetch stage with a prefetch queue between unified memory and decode. It issues word reads to `memory` from a PC starting at `START_ADDR` and buffers (pc, insn) pairs in a DEPTH-entry FIFO. It delivers them to `decode` under a valid/ready handshake. It supports decode back-pressure, memory busy, and PC redirect with flush; none of these are available in the current open-loop fetch.

---
 rtl/fetch_queue.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch stage with a DEPTH-entry prefetch queue.
// Issues single-word reads from fetch_pc, buffers (pc, insn) pairs and hands
// them to decode over a valid/ready handshake. Supports decode back-pressure,
// memory busy, and redirect with flush.
// Optional macro FETCH_BYPASS_EN: when the queue is empty an arriving response
// is presented to decode combinationally in the same cycle.
module fetch_queue #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = 32'h80020000
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable_fetch,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_enable,
  output logic                  mem_rw,
  output logic [1:0]            mem_access_size,
  input  logic                  mem_busy,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic [DATA_WIDTH-1:0] insn,
  output logic [ADDR_WIDTH-1:0] pc_decode,
  output logic                  insn_valid,
  input  logic                  decode_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [ADDR_WIDTH-1:0] r_resp_pc;
  logic                  r_inflight;
  logic [CW-1:0]         r_count;
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [DATA_WIDTH-1:0] r_q_insn [DEPTH];
  logic [ADDR_WIDTH-1:0] r_q_pc   [DEPTH];
  logic [DATA_WIDTH-1:0] r_insn;
  logic [ADDR_WIDTH-1:0] r_pc_decode;
  logic                  r_insn_valid;

  logic                  w_flush;
  logic [CW-1:0]         w_occ;
  logic                  w_req;
  logic                  w_accept;
  logic                  w_pop_q;
  logic                  w_byp_take;
  logic                  w_push;
  logic [CW-1:0]         w_cnt_n;
  logic [PW-1:0]         w_rptr_n;
  logic                  w_remain0;
  logic [DATA_WIDTH-1:0] w_head_insn;
  logic [ADDR_WIDTH-1:0] w_head_pc;

  // Redirect only flushes once fetch has started; in IDLE it just loads the PC.
  assign w_flush  = redirect && (r_state != S_IDLE);
  // Occupancy includes the in-flight slot so a response always has room.
  assign w_occ    = r_count + CW'(r_inflight);
  assign w_req    = (r_state == S_RUN) && (w_occ < CW'(DEPTH)) && !redirect;
  assign w_accept = w_req && !mem_busy;
  assign w_pop_q  = r_insn_valid && decode_ready;

  assign mem_enable      = w_req;
  assign mem_address     = r_fetch_pc;
  assign mem_rw          = 1'b1;
  assign mem_access_size = 2'b00;

`ifdef FETCH_BYPASS_EN
  logic w_byp;
  // Empty queue plus arriving response: show it to decode right away.
  assign w_byp      = r_inflight && (r_count == '0);
  assign w_byp_take = w_byp && decode_ready;
  assign insn_valid = r_insn_valid || w_byp;
  assign insn       = (!r_insn_valid && w_byp) ? mem_data_out : r_insn;
  assign pc_decode  = (!r_insn_valid && w_byp) ? r_resp_pc    : r_pc_decode;
`else
  assign w_byp_take = 1'b0;
  assign insn_valid = r_insn_valid;
  assign insn       = r_insn;
  assign pc_decode  = r_pc_decode;
`endif

  // A response consumed through the bypass never enters the queue; redirect drops it.
  assign w_push    = r_inflight && !w_flush && !w_byp_take;
  assign w_cnt_n   = r_count + CW'(w_push) - CW'(w_pop_q);
  assign w_rptr_n  = r_rptr + PW'(w_pop_q);
  assign w_remain0 = (r_count == CW'(w_pop_q));

  // Next head: oldest remaining entry, else the entry being pushed, else hold.
  always_comb begin
    w_head_insn = r_insn;
    w_head_pc   = r_pc_decode;
    if (!w_remain0) begin
      w_head_insn = r_q_insn[w_rptr_n];
      w_head_pc   = r_q_pc[w_rptr_n];
    end else if (w_push || w_byp_take) begin
      w_head_insn = mem_data_out;
      w_head_pc   = r_resp_pc;
    end
  end

  // Fetch control FSM.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (enable_fetch) r_state <= S_RUN;
        S_RUN:   if (!enable_fetch) r_state <= S_DRAIN;
        S_DRAIN: begin
          if (enable_fetch)                         r_state <= S_RUN;
          else if ((r_count == '0) && !r_inflight)  r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // PC, in-flight tracking, queue pointers and registered decode head.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_fetch_pc   <= START_ADDR;
      r_resp_pc    <= '0;
      r_inflight   <= 1'b0;
      r_count      <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_insn       <= '0;
      r_pc_decode  <= '0;
      r_insn_valid <= 1'b0;
    end else if (w_flush) begin
      r_fetch_pc   <= redirect_pc;
      r_inflight   <= 1'b0;
      r_count      <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_insn_valid <= 1'b0;
    end else begin
      if (redirect)      r_fetch_pc <= redirect_pc;
      else if (w_accept) r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(3'd4);
      if (w_accept)      r_resp_pc  <= r_fetch_pc;
      r_inflight   <= w_accept;
      r_count      <= w_cnt_n;
      r_wptr       <= r_wptr + PW'(w_push);
      r_rptr       <= w_rptr_n;
      r_insn_valid <= (w_cnt_n != '0);
      r_insn       <= w_head_insn;
      r_pc_decode  <= w_head_pc;
    end
  end

  // Queue storage; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_q_insn[r_wptr] <= mem_data_out;
      r_q_pc[r_wptr]   <= r_resp_pc;
    end
  end

`ifndef SYNTHESIS
  // The request throttle must make overflow unreachable.
  always_ff @(posedge clock) begin
    if (reset_n) assert (!(w_push && (r_count == CW'(DEPTH))))
      else $error("fetch_queue: push into full queue");
  end
`endif

endmodule
